// File: rtl/dm_sba_apb_bridge.sv
// dm_sba_apb_bridge
// Bridges the debug module's 64-bit single-beat SBA host port onto a 32-bit
// APB requester. A request becomes one or two APB transfers: the lo word goes
// first if any of be[3:0] is set, then the hi word if any of be[7:4] is set.
// Exactly one response pulse is returned per request.
//
// Ports:
//   core_clk, sys_rst_n        clock, async active-low reset
//   host_req_i/add/we/wdata/be SBA request; host_gnt_o accepts it (IDLE only)
//   host_r_valid_o/rdata_o     one-cycle response; rdata is 0 for writes and
//                              for halves not accessed
//   psel/penable/pwrite/paddr/pwdata_o, prdata/pready/pslverr_i   APB
//   err_o / err_clr_i          sticky error (slverr, timeout, bad address)
module dm_sba_apb_bridge #(
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 core_clk,
  input  logic                 sys_rst_n,
  input  logic                 host_req_i,
  input  logic [63:0]          host_add_i,
  input  logic                 host_we_i,
  input  logic [63:0]          host_wdata_i,
  input  logic [7:0]           host_be_i,
  output logic                 host_gnt_o,
  output logic                 host_r_valid_o,
  output logic [63:0]          host_r_rdata_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [AddrWidth-1:0] paddr_o,
  output logic [31:0]          pwdata_o,
  input  logic [31:0]          prdata_i,
  input  logic                 pready_i,
  input  logic                 pslverr_i,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                 state_q;
  logic [AddrWidth-1:3]   add_q;
  logic                   we_q;
  logic [63:0]            wdata_q;
  logic                   lo_pend_q, hi_pend_q;
  logic [63:0]            rdata_q, rdata_d;
  logic [CntW-1:0]        wcnt_q;
  logic                   psel_q, penable_q, pwrite_q, r_valid_q, err_q;
  logic [AddrWidth-1:0]   paddr_q;
  logic [31:0]            pwdata_q;
  logic [63:0]            r_rdata_q;

  logic oor, tmo, err_set, host_lo;
  logic unused_add_lsb;

  assign unused_add_lsb = ^host_add_i[2:0];

  if (AddrWidth < 64) begin : g_oor
    assign oor = |host_add_i[63:AddrWidth];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  assign host_gnt_o = host_req_i && (state_q == IDLE);
  assign host_lo    = |host_be_i[3:0];
  assign tmo        = (wcnt_q == CntW'(TimeoutCycles - 1));

  assign err_set = (host_gnt_o && oor) ||
                   ((state_q == ACCESS) && ((pready_i && pslverr_i) || (!pready_i && tmo)));

  // Read data with the completing half's slice merged in; the lo half is
  // always the one in flight while its pending bit is still set.
  always_comb begin
    rdata_d = rdata_q;
    if (lo_pend_q) rdata_d[31:0]  = pslverr_i ? 32'h0 : prdata_i;
    else           rdata_d[63:32] = pslverr_i ? 32'h0 : prdata_i;
  end

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      add_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      lo_pend_q <= 1'b0;
      hi_pend_q <= 1'b0;
      rdata_q   <= '0;
      wcnt_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      // set beats clear when both land in the same cycle
      if (err_set)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          r_valid_q <= 1'b0;
          r_rdata_q <= '0;
          if (host_req_i) begin
            add_q     <= host_add_i[AddrWidth-1:3];
            we_q      <= host_we_i;
            wdata_q   <= host_wdata_i;
            lo_pend_q <= host_lo;
            hi_pend_q <= |host_be_i[7:4];
            rdata_q   <= '0;
            if (oor || host_be_i == 8'h00) begin
              state_q   <= RESP;
              r_valid_q <= 1'b1;
            end else begin
              state_q   <= SETUP;
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              pwrite_q  <= host_we_i;
              paddr_q   <= {host_add_i[AddrWidth-1:3], ~host_lo, 2'b00};
              pwdata_q  <= host_lo ? host_wdata_i[31:0] : host_wdata_i[63:32];
            end
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          wcnt_q    <= '0;
          state_q   <= ACCESS;
        end

        ACCESS: begin
          if (pready_i) begin
            if (!we_q) rdata_q <= rdata_d;
            if (lo_pend_q) lo_pend_q <= 1'b0;
            else           hi_pend_q <= 1'b0;
            if (lo_pend_q && hi_pend_q) begin
              state_q   <= SETUP;
              penable_q <= 1'b0;
              paddr_q   <= {add_q, 3'b100};
              pwdata_q  <= wdata_q[63:32];
            end else begin
              state_q   <= RESP;
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              r_valid_q <= 1'b1;
              r_rdata_q <= we_q ? 64'h0 : rdata_d;
            end
          end else if (tmo) begin
            // abort: remaining halves are dropped, their slices stay 0
            state_q   <= RESP;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            lo_pend_q <= 1'b0;
            hi_pend_q <= 1'b0;
            r_valid_q <= 1'b1;
            r_rdata_q <= we_q ? 64'h0 : rdata_q;
          end else if (wcnt_q != '1) begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end

        RESP: begin
          r_valid_q <= 1'b0;
          r_rdata_q <= '0;
          state_q   <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_r_valid_o = r_valid_q;
  assign host_r_rdata_o = r_rdata_q;
  assign psel_o         = psel_q;
  assign penable_o      = penable_q;
  assign pwrite_o       = pwrite_q;
  assign paddr_o        = paddr_q;
  assign pwdata_o       = pwdata_q;
  assign err_o          = err_q;

endmodule

// File: doc/dm_sba_apb_bridge.md
# dm_sba_apb_bridge

Responder for the debug module's system-bus-access (SBA) host port. It accepts 64-bit single-beat requests from `dm_top` (`host_*`) and turns them into one or two 32-bit APB transfers toward peripheral space. It returns one response pulse per request. It sits in the FPGA top level between `dm_top` and the APB peripherals, such as the UART, so that a debugger can access registers without halting the core.

## Interface
Parameters:
- `AddrWidth`, 32: APB address width. Host address bits at or above this width must be zero.
- `TimeoutCycles`, 1024: maximum number of ACCESS cycles waiting for `pready_i` before the transfer is aborted. Must be at least 2.

Ports:
- `core_clk`  in  1  clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `host_req_i`  in  1  SBA request.
- `host_add_i`  in  64  byte address.
- `host_we_i`  in  1  1 = write.
- `host_wdata_i`  in  64  write data.
- `host_be_i`  in  8  byte enables.
- `host_gnt_o`  out  1  request accepted.
- `host_r_valid_o`  out  1  response pulse, issued for reads and writes.
- `host_r_rdata_o`  out  64  read data, valid while `host_r_valid_o` is high.
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB control.
- `paddr_o`  out  AddrWidth  APB address.
- `pwdata_o`  out  32  APB write data.
- `prdata_i`  in  32  APB read data.
- `pready_i`, `pslverr_i`  in  1  APB completion and error.
- `err_o`  out  1  sticky error flag.
- `err_clr_i`  in  1  clears `err_o`.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `host_gnt_o = host_req_i`. This is combinational, high only in IDLE.
  - On grant, register address, we, wdata and be.
  - Compute `lo_pend = |be[3:0]` and `hi_pend = |be[7:4]`.
  - Clear the read-data register.
- **Grant with out-of-range address** (`host_add_i[63:AddrWidth] != 0`): no APB traffic, set `err_o`, go to RESP.
- **Grant with `be == 0`**: no APB traffic, go to RESP.
- **Grant otherwise**: go to SETUP.
- **Half order**: the lo half goes first if pending, then the hi half.
  - lo: `paddr = {add[AddrWidth-1:3], 3'b000}`, `pwdata = wdata[31:0]`.
  - hi: `paddr = {add[AddrWidth-1:3], 3'b100}`, `pwdata = wdata[63:32]`.
  - APB has no strobes, so a partial be within a half writes the full 32-bit word. This is accepted behaviour.
- **SETUP**: `psel = 1`, `penable = 0`, `pwrite = we`. Next state is ACCESS.
- **ACCESS**: `psel = 1`, `penable = 1`. Hold `paddr`, `pwrite` and `pwdata` stable.
  - On `pready_i`:
    - Read: capture `prdata_i` into the half's slice of rdata, or zero if `pslverr_i`.
    - If `pslverr_i`: set `err_o`.
    - Clear this half's pending bit.
    - If another half is pending, go to SETUP; otherwise go to RESP.
  - If the wait counter reaches `TimeoutCycles-1` without `pready_i`:
    - Abort: drop `psel`/`penable` next cycle.
    - Set `err_o`.
    - Discard remaining halves; their rdata slices stay 0.
    - Go to RESP.
- **RESP**: `host_r_valid_o = 1` for exactly one cycle, with `host_r_rdata_o = rdata`. Next state is IDLE.
- **Data lanes**: slices of halves not accessed read as 0. For writes, `host_r_rdata_o = 0`.
- **Wait counter**: reset on entry to ACCESS; saturates and never wraps.
- **`err_o`**:
  - Set on slverr, timeout or out-of-range address.
  - Cleared by `err_clr_i`.
  - A set in the same cycle as a clear wins.

## Timing
- Reset: all outputs are 0 and the FSM is in IDLE.
- Reset asserted mid-transfer aborts immediately: `psel`/`penable` drop asynchronously and no response is issued.
- Grant at cycle T; the request is registered at the T→T+1 edge.
- Single half, `pready` high in the first ACCESS cycle:
  - SETUP at T+1, ACCESS at T+2, RESP at T+3.
  - Latency is 3 cycles.
- Both halves: SETUP T+1, ACCESS T+2, SETUP T+3, ACCESS T+4, RESP T+5.
- Each APB wait state adds 1 cycle.
- `be == 0` or out-of-range address: RESP at T+1.
- A new request is not granted during RESP. The earliest next grant is the cycle after RESP.
- `paddr_o`, `pwrite_o` and `pwdata_o` are registered. They may hold stale values outside SETUP/ACCESS; slaves qualify them with `psel`.
- Timeout with `TimeoutCycles = N`: abort after N ACCESS cycles, RESP on the following cycle.

## Test plan
- Read `add=0x0000_0000_C000_0008`, `be=0x0F`, slave returns `0x1234_5678` with 0 waits:
  - one APB read at `paddr=0xC000_0008`;
  - `r_valid` at T+3 with `rdata=0x0000_0000_1234_5678`.
- Write `add=0xC000_0000`, `be=0xFF`, `wdata=0xAAAA_BBBB_CCCC_DDDD`, 2 wait states per access:
  - APB writes `0xCCCC_DDDD`@`0xC000_0000`, then `0xAAAA_BBBB`@`0xC000_0004`;
  - `r_valid` at T+9; `err_o = 0`.
- Read with `be=0xF0`, `pslverr=1`:
  - single access at `+4`;
  - `rdata = 0`, `err_o = 1`;
  - `err_clr_i` pulse → `err_o = 0`.
- `pready` held low, `TimeoutCycles=16`:
  - `psel` drops after 16 ACCESS cycles;
  - `r_valid` on the next cycle; `err_o = 1`;
  - the hi half is never issued.
- `be=0x00`: no `psel`, `r_valid` at T+1.
- `add=0x1_0000_0000`: no `psel`, `r_valid` at T+1, `err_o = 1`.
- Assert `sys_rst_n` low during ACCESS:
  - all outputs go to 0 immediately;
  - after release, the next request completes normally.
